alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Shares the single 16-bit ALU between two independent requesters, e.g. the execute stage (port 0) and the multicycle/debug unit (port 1).
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, registers the selected operands and ctl into the ALU, then captures result and flags into a held response register for the winning requester.

Parameters:
- WIDTH, 16, operand/result width.
- CTLW, 3, ALU control width (ADD/SUB/PADDSB/RED/SLL/SRA/ROR/XOR encodings, passed through unchanged).
- FLGW, 3, ALU flag width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  arbiter accepts requester 0 this cycle.
- req0_a, req0_b  input  WIDTH  operands, requester 0.
- req0_ctl  input  CTLW  ALU op, requester 0.
- rsp0_valid  output  1  response for requester 0 held.
- rsp0_ready  input  1  requester 0 consumes response.
- rsp0_result  output  WIDTH  captured result.
- rsp0_flags  output  FLGW  captured flags.
- req1_*/rsp1_*  same as port 0, requester 1.
- alu_a, alu_b  output  WIDTH  registered ALU operands.
- alu_ctl  output  CTLW  registered ALU op.
- alu_result  input  WIDTH  ALU result (combinational from alu_a/b/ctl).
- alu_flags  input  FLGW  ALU flags.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, req*_ready=0 while in reset, rsp*_valid=0, rsp*_result=0, rsp*_flags=0, alu_a=alu_b=0, alu_ctl=0, owner=0, last_grant=1 (so port 0 wins the first tie). Any in-flight op is dropped, with no response.
- States: IDLE, EXEC, RESP.
- Grant, combinational, evaluated only when the block can accept:
  - one valid → that port;
  - both valid → the port != last_grant;
  - neither → none.
- reqN_ready = grantN & accept_ok, where accept_ok = (state==IDLE) | (state==RESP & rsp_fire).
- rsp_fire = rsp<owner>_valid & rsp<owner>_ready. This creates a combinational ready path from rsp_ready to req_ready, which is intended.
- Accept (reqN_valid & reqN_ready):
  - latch reqN_a/b/ctl into alu_a/b/ctl;
  - owner<=N, last_grant<=N;
  - state<=EXEC.
- EXEC (exactly 1 cycle):
  - rsp<owner>_result<=alu_result, rsp<owner>_flags<=alu_flags;
  - rsp<owner>_valid<=1;
  - state<=RESP.
- RESP:
  - rsp<owner>_valid held with result/flags stable until rsp_fire.
  - On rsp_fire, rsp<owner>_valid<=0.
  - If a request is accepted in the same cycle → EXEC, otherwise → IDLE.
- Latency: accept in cycle N → rsp_valid high in cycle N+2.
- Max throughput: one op per 2 cycles (back-to-back via RESP fire + accept).
- The non-owner's rsp_valid is always 0; the other port's response registers are untouched.
- alu_a/b/ctl hold their last value when IDLE; there is no re-drive to 0.
- A requester holds a/b/ctl stable while valid & !ready. The arbiter may move the grant between cycles while nothing fires.
- A requester waiting while the other is served wins the next accept (round-robin), so there is no starvation.
- All 8 ctl codes are legal. Flags are passed through raw; interpretation belongs to the consumer.
- Simultaneous rsp_fire and a new accept from either port: the response clears and the new op is latched in the same edge. If the new op is for the same port, its rsp_valid still drops for ≥1 cycle (the EXEC cycle).

Test Plan:
- Reset then req0 ADD a=16'h0003 b=16'h0004, rsp0_ready=1 → req0_ready=1 in cycle 0, rsp0_valid=1 in cycle 2 with result 16'h0007, then rsp0_valid=0; rsp1_valid stays 0.
- Both valid at the first cycle after reset (req0 SUB 16'h0010−16'h0001, req1 XOR 16'hFF00^16'h0F0F) → port 0 served first (result 16'h000F), port 1 next (result 16'hF00F). Then both requesters are re-asserted → port 0 wins the next accept.
- Backpressure: req1 SLL op, rsp1_ready=0 for 5 cycles → rsp1_valid and result held constant, req0_ready=0 throughout. Raise rsp1_ready → a pending req0 is accepted in the same cycle.
- Back-to-back: req0 valid continuously with 4 ops, rsp0_ready=1 → accepts every 2 cycles, results in order, no drops or duplicates.
- Async reset asserted during EXEC (mid-edge, between clocks) → all rsp_valid=0 and alu_a/b/ctl=0 immediately. After release, the dropped op produces no response, and the next tie grants port 0.
- Single requester repeatedly (req1 only, 3 ops) → port 1 served every time despite last_grant=1; no stall waiting for port 0.

Source files
------------

// File: rtl/alu_share_arb_if.sv
// Bundle of both requester channels and the shared ALU operand/result bus.
// The slave modport is the arbiter; the master modport is the requesters plus the ALU.
interface alu_share_arb_if #(
    parameter int WIDTH = 16,
    parameter int CTLW  = 3,
    parameter int FLGW  = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [CTLW-1:0]  req0_ctl;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_result;
    logic [FLGW-1:0]  rsp0_flags;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [CTLW-1:0]  req1_ctl;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_result;
    logic [FLGW-1:0]  rsp1_flags;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [CTLW-1:0]  alu_ctl;
    logic [WIDTH-1:0] alu_result;
    logic [FLGW-1:0]  alu_flags;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctl, rsp0_ready,
        input  req1_valid, req1_a, req1_b, req1_ctl, rsp1_ready,
        input  alu_result, alu_flags,
        output req0_ready, rsp0_valid, rsp0_result, rsp0_flags,
        output req1_ready, rsp1_valid, rsp1_result, rsp1_flags,
        output alu_a, alu_b, alu_ctl
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctl, rsp0_ready,
        output req1_valid, req1_a, req1_b, req1_ctl, rsp1_ready,
        output alu_result, alu_flags,
        input  req0_ready, rsp0_valid, rsp0_result, rsp0_flags,
        input  req1_ready, rsp1_valid, rsp1_result, rsp1_flags,
        input  alu_a, alu_b, alu_ctl
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// Operands are registered into the ALU; the result is held per-port until consumed.
module alu_share_arb #(
    parameter int WIDTH = 16,
    parameter int CTLW  = 3,
    parameter int FLGW  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arb_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             owner;
    logic             last_grant;
    logic             grant0, grant1;
    logic             rsp_fire;
    logic             accept_ok;
    logic             accept0, accept1;

    logic             rsp0_valid_q, rsp1_valid_q;
    logic [WIDTH-1:0] rsp0_result_q, rsp1_result_q;
    logic [FLGW-1:0]  rsp0_flags_q, rsp1_flags_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    logic [CTLW-1:0]  alu_ctl_q;

    // The owner's response firing opens the accept window in the same cycle,
    // so rsp_ready reaches req_ready combinationally on purpose.
    always_comb begin
        grant0    = bus.req0_valid & (~bus.req1_valid | last_grant);
        grant1    = bus.req1_valid & (~bus.req0_valid | ~last_grant);
        rsp_fire  = owner ? (rsp1_valid_q & bus.rsp1_ready)
                          : (rsp0_valid_q & bus.rsp0_ready);
        accept_ok = (state == IDLE) | ((state == RESP) & rsp_fire);
        accept0   = grant0 & accept_ok;
        accept1   = grant1 & accept_ok;
    end

    // Ready is forced low while reset is asserted; the flops ignore accepts then anyway.
    assign bus.req0_ready  = accept0 & rst_n;
    assign bus.req1_ready  = accept1 & rst_n;
    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.rsp0_result = rsp0_result_q;
    assign bus.rsp1_result = rsp1_result_q;
    assign bus.rsp0_flags  = rsp0_flags_q;
    assign bus.rsp1_flags  = rsp1_flags_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_ctl     = alu_ctl_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the processes are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: state_nxt gets its default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept0 | accept1) state_nxt = EXEC;
            EXEC: state_nxt = RESP;
            RESP: if (rsp_fire) state_nxt = (accept0 | accept1) ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner         <= 1'b0;
            last_grant    <= 1'b1;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_ctl_q     <= '0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp1_result_q <= '0;
            rsp0_flags_q  <= '0;
            rsp1_flags_q  <= '0;
        end else begin
            if (accept0 | accept1) begin
                alu_a_q    <= accept1 ? bus.req1_a   : bus.req0_a;
                alu_b_q    <= accept1 ? bus.req1_b   : bus.req0_b;
                alu_ctl_q  <= accept1 ? bus.req1_ctl : bus.req0_ctl;
                owner      <= accept1;
                last_grant <= accept1;
            end

            if (state == EXEC) begin
                if (owner) begin
                    rsp1_result_q <= bus.alu_result;
                    rsp1_flags_q  <= bus.alu_flags;
                    rsp1_valid_q  <= 1'b1;
                end else begin
                    rsp0_result_q <= bus.alu_result;
                    rsp0_flags_q  <= bus.alu_flags;
                    rsp0_valid_q  <= 1'b1;
                end
            end

            // Clears the outgoing owner's response even if a new accept retargets owner.
            if ((state == RESP) && rsp_fire) begin
                if (owner) rsp1_valid_q <= 1'b0;
                else       rsp0_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: a vector table of single ops plus hand-written
// sequences for arbitration ties, backpressure, back-to-back issue and mid-op reset.
module tb_alu_share_arb;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_SLL = 3'd4;
    localparam logic [2:0] OP_SRA = 3'd5;
    localparam logic [2:0] OP_ROR = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;

    typedef struct {
        logic        port;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  ctl;
        logic [15:0] exp_result;
        logic [2:0]  exp_flags;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    alu_share_arb_if #(.WIDTH(16), .CTLW(3), .FLGW(3)) bus ();

    alu_share_arb #(.WIDTH(16), .CTLW(3), .FLGW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU; flags = {negative, zero, odd parity}.
    always_comb begin
        logic [15:0] r;
        logic [4:0]  sh;
        r  = '0;
        sh = {1'b0, bus.alu_b[3:0]};
        case (bus.alu_ctl)
            3'd0: r = bus.alu_a + bus.alu_b;
            3'd1: r = bus.alu_a - bus.alu_b;
            3'd2: r = {bus.alu_a[15:8] + bus.alu_b[15:8], bus.alu_a[7:0] + bus.alu_b[7:0]};
            3'd3: r = {15'd0, ^bus.alu_a};
            3'd4: r = bus.alu_a << sh;
            3'd5: r = $signed(bus.alu_a) >>> sh;
            3'd6: r = (bus.alu_a >> sh) | (bus.alu_a << (5'd16 - sh));
            default: r = bus.alu_a ^ bus.alu_b;
        endcase
        bus.alu_result = r;
        bus.alu_flags  = {r[15], (r == 16'd0), ^r};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctl = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctl = '0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
    endtask

    // Leaves the bench 1 time unit after a posedge with reset released.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive_req(input logic port, input logic [15:0] a, input logic [15:0] b,
                             input logic [2:0] ctl);
        if (port) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_ctl = ctl;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_ctl = ctl;
        end
    endtask

    // Single op on an idle arbiter with rsp_ready=1: accept now, response two cycles later.
    task automatic run_vec(input vec_t v);
        logic p;
        p = v.port;
        drive_req(p, v.a, v.b, v.ctl);
        settle();
        check("vec accept ready", p ? bus.req1_ready : bus.req0_ready, 1);
        check("vec other ready", p ? bus.req0_ready : bus.req1_ready, 0);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        settle();
        check("vec exec rsp_valid", p ? bus.rsp1_valid : bus.rsp0_valid, 0);
        check("vec alu_a", bus.alu_a, v.a);
        check("vec alu_ctl", bus.alu_ctl, v.ctl);
        step();
        settle();
        check("vec rsp_valid", p ? bus.rsp1_valid : bus.rsp0_valid, 1);
        check("vec result", p ? bus.rsp1_result : bus.rsp0_result, v.exp_result);
        check("vec flags", p ? bus.rsp1_flags : bus.rsp0_flags, v.exp_flags);
        check("vec non-owner rsp_valid", p ? bus.rsp0_valid : bus.rsp1_valid, 0);
        step();
        settle();
        check("vec rsp drop", p ? bus.rsp1_valid : bus.rsp0_valid, 0);
        step();
    endtask

    vec_t        vecs [8];
    logic [15:0] b2b_a   [4];
    logic [15:0] b2b_b   [4];
    logic [2:0]  b2b_ctl [4];
    logic [15:0] b2b_exp [4];
    logic [15:0] held;

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{1'b0, 16'h0003, 16'h0004, OP_ADD, 16'h0007, 3'b001};
        vecs[1] = '{1'b0, 16'h0005, 16'h0005, OP_SUB, 16'h0000, 3'b010};
        vecs[2] = '{1'b1, 16'hFF00, 16'h0F0F, OP_XOR, 16'hF00F, 3'b100};
        vecs[3] = '{1'b1, 16'h0001, 16'h0004, OP_SLL, 16'h0010, 3'b001};
        vecs[4] = '{1'b1, 16'h0001, 16'h0001, OP_ROR, 16'h8000, 3'b101};
        vecs[5] = '{1'b0, 16'h8000, 16'h0004, OP_SRA, 16'hF800, 3'b101};
        vecs[6] = '{1'b1, 16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 3'b010};
        vecs[7] = '{1'b0, 16'h0010, 16'h0001, OP_SUB, 16'h000F, 3'b000};

        b2b_a   = '{16'h0001, 16'h000A, 16'hAAAA, 16'h0100};
        b2b_b   = '{16'h0002, 16'h0014, 16'h5555, 16'h0001};
        b2b_ctl = '{OP_ADD, OP_ADD, OP_XOR, OP_SUB};
        b2b_exp = '{16'h0003, 16'h001E, 16'hFFFF, 16'h00FF};

        // Reset values, with a requester already valid during reset.
        idle_inputs();
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        #3;
        check("reset req0_ready", bus.req0_ready, 0);
        check("reset rsp0_valid", bus.rsp0_valid, 0);
        check("reset rsp1_valid", bus.rsp1_valid, 0);
        check("reset rsp0_result", bus.rsp0_result, 0);
        check("reset alu_a", bus.alu_a, 0);
        check("reset alu_ctl", bus.alu_ctl, 0);

        // Vector table, including three consecutive port-1-only ops.
        do_reset();
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Tie at first cycle after reset: port 0 first, then port 1, then port 0 again.
        do_reset();
        drive_req(1'b0, 16'h0010, 16'h0001, OP_SUB);
        drive_req(1'b1, 16'hFF00, 16'h0F0F, OP_XOR);
        settle();
        check("tie req0_ready", bus.req0_ready, 1);
        check("tie req1_ready", bus.req1_ready, 0);
        step();
        bus.req0_valid = 1'b0;
        settle();
        check("tie exec req1_ready", bus.req1_ready, 0);
        step();
        settle();
        check("tie rsp0_valid", bus.rsp0_valid, 1);
        check("tie rsp0_result", bus.rsp0_result, 16'h000F);
        check("tie req1_ready on fire", bus.req1_ready, 1);
        step();
        bus.req1_valid = 1'b0;
        settle();
        check("tie rsp0 dropped", bus.rsp0_valid, 0);
        step();
        drive_req(1'b0, 16'h0002, 16'h0002, OP_ADD);
        drive_req(1'b1, 16'h0003, 16'h0003, OP_ADD);
        settle();
        check("tie rsp1_valid", bus.rsp1_valid, 1);
        check("tie rsp1_result", bus.rsp1_result, 16'hF00F);
        check("tie rr req0_ready", bus.req0_ready, 1);
        check("tie rr req1_ready", bus.req1_ready, 0);

        // Backpressure on port 1 with port 0 waiting.
        do_reset();
        bus.rsp1_ready = 1'b0;
        drive_req(1'b1, 16'h0003, 16'h0002, OP_SLL);
        settle();
        check("bp req1_ready", bus.req1_ready, 1);
        step();
        bus.req1_valid = 1'b0;
        drive_req(1'b0, 16'h0001, 16'h0001, OP_ADD);
        settle();
        check("bp exec req0_ready", bus.req0_ready, 0);
        for (int c = 0; c < 5; c++) begin
            step();
            settle();
            check("bp rsp1_valid held", bus.rsp1_valid, 1);
            check("bp rsp1_result held", bus.rsp1_result, 16'h000C);
            check("bp rsp1_flags held", bus.rsp1_flags, 3'b000);
            check("bp req0_ready low", bus.req0_ready, 0);
        end
        step();
        bus.rsp1_ready = 1'b1;
        settle();
        check("bp release req0_ready", bus.req0_ready, 1);
        step();
        bus.req0_valid = 1'b0;
        settle();
        check("bp rsp1 dropped", bus.rsp1_valid, 0);
        step();
        settle();
        check("bp rsp0_valid", bus.rsp0_valid, 1);
        check("bp rsp0_result", bus.rsp0_result, 16'h0002);
        check("bp rsp0_flags", bus.rsp0_flags, 3'b001);

        // Back-to-back issue from port 0: one accept every two cycles.
        do_reset();
        drive_req(1'b0, b2b_a[0], b2b_b[0], b2b_ctl[0]);
        for (int k = 0; k < 4; k++) begin
            settle();
            check("b2b accept ready", bus.req0_ready, 1);
            step();
            if (k < 3) drive_req(1'b0, b2b_a[k+1], b2b_b[k+1], b2b_ctl[k+1]);
            else       bus.req0_valid = 1'b0;
            settle();
            check("b2b exec ready", bus.req0_ready, 0);
            check("b2b exec rsp_valid", bus.rsp0_valid, 0);
            step();
            settle();
            check("b2b rsp_valid", bus.rsp0_valid, 1);
            check("b2b result", bus.rsp0_result, b2b_exp[k]);
            #1;
        end
        step();
        settle();
        check("b2b final drop", bus.rsp0_valid, 0);

        // Async reset in the EXEC cycle: response dropped, next tie goes to port 0.
        do_reset();
        drive_req(1'b1, 16'h0001, 16'h0001, OP_ADD);
        settle();
        step();
        bus.req1_valid = 1'b0;
        settle();
        check("rr setup rsp1", bus.rsp1_valid, 0);
        step();
        settle();
        check("rr setup rsp1_valid", bus.rsp1_valid, 1);
        step();
        drive_req(1'b0, 16'h1234, 16'h0001, OP_XOR);
        settle();
        check("arst accept", bus.req0_ready, 1);
        step();
        bus.req0_valid = 1'b0;
        settle();
        check("arst exec alu_a", bus.alu_a, 16'h1234);
        held = bus.alu_b;
        check("arst exec alu_b", held, 16'h0001);
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        #1;
        check("arst rsp0_valid", bus.rsp0_valid, 0);
        check("arst rsp1_valid", bus.rsp1_valid, 0);
        check("arst alu_a", bus.alu_a, 0);
        check("arst alu_b", bus.alu_b, 0);
        check("arst alu_ctl", bus.alu_ctl, 0);
        check("arst req0_ready", bus.req0_ready, 0);
        bus.req0_valid = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("arst no stale rsp0", bus.rsp0_valid, 0);
            check("arst no stale rsp1", bus.rsp1_valid, 0);
            step();
        end
        drive_req(1'b0, 16'h0001, 16'h0001, OP_ADD);
        drive_req(1'b1, 16'h0001, 16'h0001, OP_ADD);
        settle();
        check("arst tie req0_ready", bus.req0_ready, 1);
        check("arst tie req1_ready", bus.req1_ready, 0);
        step();
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
